// File: rtl/score_counter.sv
// score_counter: up/down event counter with optional edge qualification,
// programmable terminal value, wrap/saturate boundaries, parallel load and a
// RUN/DONE machine that freezes the count at the terminal value.
module score_counter #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned MAX_COUNT   = 255,
    parameter int unsigned EDGE_MODE   = 1,
    parameter int unsigned WRAP        = 0,
    parameter int unsigned HOLD_ON_MAX = 1
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    input  logic             dec,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             at_max,
    output logic             at_min,
    output logic             tc_pulse,
    output logic             done
);

    localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX_COUNT);
    localparam bit               EDGE_EN = (EDGE_MODE != 0);
    localparam bit               WRAP_EN = (WRAP != 0);
    // Entering DONE only makes sense when the count cannot wrap past the top.
    localparam bit               HOLD_EN = (HOLD_ON_MAX != 0) && (WRAP == 0);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             tc_q, tc_d;
    logic             at_max_q, at_min_q, done_q;
    logic             inc_hist_q, dec_hist_q;
    logic             inc_ev_c, dec_ev_c;
    logic [WIDTH-1:0] load_sat_c;

    // Qualify requests: rising edge or level depending on EDGE_MODE.
    always_comb begin
        inc_ev_c = EDGE_EN ? (inc & ~inc_hist_q) : inc;
        dec_ev_c = EDGE_EN ? (dec & ~dec_hist_q) : dec;
    end

    // Next count, state and terminal pulse; priority clear > load > events.
    always_comb begin
        out_d      = out_q;
        state_d    = state_q;
        tc_d       = 1'b0;
        load_sat_c = (load_val > MAX_V) ? MAX_V : load_val;
        if (clear) begin
            out_d   = '0;
            state_d = ST_RUN;
        end else if (state_q == ST_DONE) begin
            out_d = out_q;
        end else if (load) begin
            out_d = load_sat_c;
            if (HOLD_EN && (load_sat_c == MAX_V)) begin
                state_d = ST_DONE;
            end
        end else if (inc_ev_c && !dec_ev_c) begin
            if (out_q < MAX_V) begin
                out_d = out_q + WIDTH'(1);
                if ((out_q + WIDTH'(1)) == MAX_V) begin
                    tc_d = 1'b1;
                    if (HOLD_EN) begin
                        state_d = ST_DONE;
                    end
                end
            end else if (WRAP_EN) begin
                out_d = '0;
                tc_d  = 1'b1;
            end
        end else if (dec_ev_c && !inc_ev_c) begin
            if (out_q != '0) begin
                out_d = out_q - WIDTH'(1);
            end else if (WRAP_EN) begin
                out_d = MAX_V;
                tc_d  = 1'b1;
            end
        end
    end

    // State, count and status flags, all registered from the next values.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q    <= ST_RUN;
            out_q      <= '0;
            tc_q       <= 1'b0;
            at_max_q   <= 1'b0;
            at_min_q   <= 1'b1;
            done_q     <= 1'b0;
            inc_hist_q <= 1'b1;
            dec_hist_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            out_q      <= out_d;
            tc_q       <= tc_d;
            at_max_q   <= (out_d == MAX_V);
            at_min_q   <= (out_d == '0);
            done_q     <= (state_d == ST_DONE);
            inc_hist_q <= inc;
            dec_hist_q <= dec;
        end
    end

    assign out      = out_q;
    assign at_max   = at_max_q;
    assign at_min   = at_min_q;
    assign tc_pulse = tc_q;
    assign done     = done_q;

endmodule

// File: tb/tb_score_counter.sv
// tb_score_counter: directed vectors against four parameterisations of
// score_counter that share one set of input stimulus.
module tb_score_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       inc = 1'b0;
    logic       dec = 1'b0;
    logic       ld  = 1'b0;
    logic [7:0] lv  = 8'd0;

    logic [7:0] o_lvl, o_edg;
    logic [3:0] o_wrp, o_sat;
    logic       mx_lvl, mn_lvl, tc_lvl, dn_lvl;
    logic       mx_edg, mn_edg, tc_edg, dn_edg;
    logic       mx_wrp, mn_wrp, tc_wrp, dn_wrp;
    logic       mx_sat, mn_sat, tc_sat, dn_sat;

    int n_cmp = 0;
    int n_err = 0;

    always #10 clk = ~clk;

    score_counter #(.WIDTH(8), .MAX_COUNT(255), .EDGE_MODE(0), .WRAP(1), .HOLD_ON_MAX(1)) u_lvl (
        .CLOCK_50(clk), .reset(rst), .clear(clr), .inc(inc), .dec(dec), .load(ld),
        .load_val(lv), .out(o_lvl), .at_max(mx_lvl), .at_min(mn_lvl),
        .tc_pulse(tc_lvl), .done(dn_lvl));

    score_counter #(.WIDTH(8), .MAX_COUNT(255), .EDGE_MODE(1), .WRAP(1), .HOLD_ON_MAX(1)) u_edg (
        .CLOCK_50(clk), .reset(rst), .clear(clr), .inc(inc), .dec(dec), .load(ld),
        .load_val(lv), .out(o_edg), .at_max(mx_edg), .at_min(mn_edg),
        .tc_pulse(tc_edg), .done(dn_edg));

    score_counter #(.WIDTH(4), .MAX_COUNT(9), .EDGE_MODE(1), .WRAP(1), .HOLD_ON_MAX(1)) u_wrp (
        .CLOCK_50(clk), .reset(rst), .clear(clr), .inc(inc), .dec(dec), .load(ld),
        .load_val(lv[3:0]), .out(o_wrp), .at_max(mx_wrp), .at_min(mn_wrp),
        .tc_pulse(tc_wrp), .done(dn_wrp));

    score_counter #(.WIDTH(4), .MAX_COUNT(9), .EDGE_MODE(1), .WRAP(0), .HOLD_ON_MAX(1)) u_sat (
        .CLOCK_50(clk), .reset(rst), .clear(clr), .inc(inc), .dec(dec), .load(ld),
        .load_val(lv[3:0]), .out(o_sat), .at_max(mx_sat), .at_min(mn_sat),
        .tc_pulse(tc_sat), .done(dn_sat));

    // Compare one observed value against its expected value.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_out",  32'(o_lvl),  32'd0);
        chk("rst_min",  32'(mn_lvl), 32'd1);
        chk("rst_max",  32'(mx_lvl), 32'd0);
        chk("rst_tc",   32'(tc_lvl), 32'd0);
        chk("rst_done", 32'(dn_sat), 32'd0);

        // Level counting
        for (int i = 0; i < 5; i++) step();
        chk("lvl_idle_out", 32'(o_lvl),  32'd0);
        chk("lvl_idle_min", 32'(mn_lvl), 32'd1);
        inc = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            step();
            chk("lvl_out", 32'(o_lvl), 32'(i));
            if (i == 1) chk("lvl_min_drop", 32'(mn_lvl), 32'd0);
        end
        // Level-mode wrap through the top
        inc = 1'b0;
        ld  = 1'b1;
        lv  = 8'd254;
        step();
        ld  = 1'b0;
        chk("lvl_load", 32'(o_lvl), 32'd254);
        inc = 1'b1;
        step();
        chk("lvl_top_out", 32'(o_lvl),  32'd255);
        chk("lvl_top_tc",  32'(tc_lvl), 32'd1);
        chk("lvl_top_max", 32'(mx_lvl), 32'd1);
        step();
        chk("lvl_wrap_out", 32'(o_lvl),  32'd0);
        chk("lvl_wrap_tc",  32'(tc_lvl), 32'd1);
        chk("lvl_wrap_min", 32'(mn_lvl), 32'd1);
        step();
        chk("lvl_after_out", 32'(o_lvl),  32'd1);
        chk("lvl_after_tc",  32'(tc_lvl), 32'd0);
        inc = 1'b0;

        // Edge mode
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        inc = 1'b1;
        for (int i = 0; i < 10; i++) step();
        chk("edge_held", 32'(o_edg), 32'd1);
        for (int i = 0; i < 3; i++) begin
            inc = 1'b0;
            step();
            inc = 1'b1;
            step();
        end
        chk("edge_toggle", 32'(o_edg), 32'd4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("edge_thru_rst", 32'(o_edg), 32'd0);
        inc = 1'b0;

        // Wrap at both ends
        rst = 1'b1;
        step();
        rst = 1'b0;
        ld  = 1'b1;
        lv  = 8'd9;
        step();
        ld  = 1'b0;
        chk("wrp_load",  32'(o_wrp),  32'd9);
        chk("wrp_max",   32'(mx_wrp), 32'd1);
        chk("wrp_nodone",32'(dn_wrp), 32'd0);
        chk("wrp_ld_tc", 32'(tc_wrp), 32'd0);
        inc = 1'b1;
        step();
        chk("wrp_up_out", 32'(o_wrp),  32'd0);
        chk("wrp_up_tc",  32'(tc_wrp), 32'd1);
        inc = 1'b0;
        step();
        chk("wrp_up_tc_end", 32'(tc_wrp), 32'd0);
        dec = 1'b1;
        step();
        chk("wrp_dn_out", 32'(o_wrp),  32'd9);
        chk("wrp_dn_tc",  32'(tc_wrp), 32'd1);
        dec = 1'b0;
        step();
        chk("wrp_dn_tc_end", 32'(tc_wrp), 32'd0);

        // Saturate and DONE
        rst = 1'b1;
        step();
        rst = 1'b0;
        ld  = 1'b1;
        lv  = 8'd8;
        step();
        ld  = 1'b0;
        chk("sat_load", 32'(o_sat),  32'd8);
        chk("sat_run",  32'(dn_sat), 32'd0);
        inc = 1'b1;
        step();
        chk("sat_top_out",  32'(o_sat),  32'd9);
        chk("sat_top_tc",   32'(tc_sat), 32'd1);
        chk("sat_top_done", 32'(dn_sat), 32'd1);
        chk("sat_top_max",  32'(mx_sat), 32'd1);
        inc = 1'b0;
        step();
        chk("sat_tc_end", 32'(tc_sat), 32'd0);
        dec = 1'b1;
        step();
        dec = 1'b0;
        step();
        chk("done_dec", 32'(o_sat), 32'd9);
        ld = 1'b1;
        lv = 8'd3;
        step();
        ld = 1'b0;
        chk("done_load",    32'(o_sat),  32'd9);
        chk("done_load_dn", 32'(dn_sat), 32'd1);
        inc = 1'b1;
        step();
        chk("done_inc",    32'(o_sat),  32'd9);
        chk("done_inc_tc", 32'(tc_sat), 32'd0);
        inc = 1'b0;
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_out",  32'(o_sat),  32'd0);
        chk("clr_done", 32'(dn_sat), 32'd0);
        chk("clr_min",  32'(mn_sat), 32'd1);

        // Conflicts
        ld = 1'b1;
        lv = 8'd5;
        step();
        ld  = 1'b0;
        inc = 1'b1;
        dec = 1'b1;
        step();
        chk("both_out", 32'(o_sat),  32'd5);
        chk("both_tc",  32'(tc_sat), 32'd0);
        inc = 1'b0;
        dec = 1'b0;
        step();
        ld  = 1'b1;
        lv  = 8'd2;
        inc = 1'b1;
        step();
        chk("load_vs_inc", 32'(o_sat), 32'd2);
        ld  = 1'b0;
        inc = 1'b0;
        step();
        chk("load_hold", 32'(o_sat), 32'd2);
        ld = 1'b1;
        lv = 8'd15;
        step();
        ld = 1'b0;
        chk("load_clamp",      32'(o_sat),  32'd9);
        chk("load_clamp_done", 32'(dn_sat), 32'd1);
        chk("load_clamp_tc",   32'(tc_sat), 32'd0);
        clr = 1'b1;
        ld  = 1'b1;
        lv  = 8'd3;
        step();
        clr = 1'b0;
        ld  = 1'b0;
        chk("clr_vs_load",      32'(o_sat),  32'd0);
        chk("clr_vs_load_done", 32'(dn_sat), 32'd0);

        // Floor
        for (int i = 0; i < 3; i++) begin
            dec = 1'b1;
            step();
            chk("floor_out", 32'(o_sat),  32'd0);
            chk("floor_min", 32'(mn_sat), 32'd1);
            chk("floor_tc",  32'(tc_sat), 32'd0);
            dec = 1'b0;
            step();
            chk("floor_tc_idle", 32'(tc_sat), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
